// File: rtl/host_link_pkg.sv
// Shared types and helpers for the host link multiplexer: FSM encodings,
// byte type and the round-robin picker.
package host_link_pkg;

  localparam int LEN_W = 8;

  typedef logic [LEN_W-1:0] byte_t;

  typedef enum logic [1:0] {TX_IDLE, TX_CHAN, TX_LEN, TX_DATA} tx_state_e;
  typedef enum logic [1:0] {RX_CHAN, RX_LEN, RX_DATA} rx_state_e;

  // First requester strictly after ptr (wrapping at n); returns ptr if none.
  function automatic logic [2:0] rr_next(input logic [7:0] req,
                                         input logic [2:0] ptr,
                                         input int n);
    logic [2:0] sel;
    logic [2:0] idx;
    logic       found;
    sel   = ptr;
    found = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      idx = 3'((int'(ptr) + i) % n);
      if (i <= n && !found && req[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/host_link_hold.sv
// One-entry hold/skid stage behind a FIFO whose data lags rden by one cycle.
// The byte on the FIFO bus passes straight through; it is parked only when not drained.
module host_link_hold #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         fetch,
  input  logic [W-1:0] din,
  input  logic         drain,
  output logic         valid,
  output logic [W-1:0] dout
);

  logic         pend;
  logic         full;
  logic [W-1:0] data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= 1'b0;
      full <= 1'b0;
      data <= '0;
    end else begin
      pend <= fetch;
      if (pend && !drain && !full) begin
        data <= din;
        full <= 1'b1;
      end else if (full && drain) begin
        full <= 1'b0;
      end
    end
  end

  assign valid = pend | full;
  assign dout  = full ? data : din;

endmodule

// File: rtl/host_link_mux.sv
// Muxes NCH byte-stream clients onto one transport FIFO pair with a channel-byte prefix.
// Define HOST_LINK_MUX_DROPCNT_EN to add the saturating rx_dropped bad-frame counter.
module host_link_mux
  import host_link_pkg::*;
#(
  parameter int NCH = 2
) (
  input  logic             CLK,
  input  logic             RESETn,
  output logic             com_rden,
  input  logic             com_rdempty,
  input  logic [7:0]       com_rddata,
  output logic             com_wren,
  input  logic             com_wrfull,
  output logic [7:0]       com_wrdata,
  output logic [NCH-1:0]   c_rden,
  input  logic [NCH-1:0]   c_rdempty,
  input  logic [8*NCH-1:0] c_rddata,
  output logic [NCH-1:0]   c_wren,
  input  logic [NCH-1:0]   c_wrfull,
  output logic [7:0]       c_wrdata,
`ifdef HOST_LINK_MUX_DROPCNT_EN
  output logic [15:0]      rx_dropped,
`endif
  output logic             tx_busy,
  output logic             rx_busy
);

  localparam int CHW = $clog2(NCH);

  // Blocks FIFO reads while reset is asserted and for the first cycle after.
  logic live;

  // ---------------- outbound ----------------
  tx_state_e      tx_st, tx_nx;
  logic [CHW-1:0] gnt, rr_ptr, gnt_nx;
  logic           len_req;
  byte_t          tx_cnt, tx_left;
  logic           tx_fetch, tx_drain, tx_vld, tx_want, any_req;
  byte_t          tx_din, tx_dout;
  logic [7:0]     req8;

  always_comb begin
    req8             = '0;
    req8[NCH-1:0]    = ~c_rdempty;
    any_req          = |req8;
    gnt_nx           = CHW'(rr_next(req8, 3'(rr_ptr), NCH));
  end

  assign tx_din = c_rddata[int'(gnt)*8 +: 8];

  always_comb begin
    tx_nx      = tx_st;
    tx_drain   = 1'b0;
    tx_want    = 1'b0;
    com_wren   = 1'b0;
    com_wrdata = '0;
    case (tx_st)
      TX_IDLE: if (any_req) tx_nx = TX_CHAN;
      TX_CHAN: begin
        tx_want = !len_req;
        if (!com_wrfull) begin
          com_wren   = 1'b1;
          com_wrdata = byte_t'(gnt);
          tx_nx      = TX_LEN;
        end
      end
      TX_LEN: begin
        tx_want = !len_req;
        if (tx_vld && !com_wrfull) begin
          tx_drain   = 1'b1;
          com_wren   = 1'b1;
          com_wrdata = tx_dout;
          tx_want    = (tx_dout != '0);
          tx_nx      = (tx_dout == '0) ? TX_IDLE : TX_DATA;
        end
      end
      TX_DATA: begin
        tx_want = (tx_left != '0);
        if (tx_vld && !com_wrfull) begin
          tx_drain   = 1'b1;
          com_wren   = 1'b1;
          com_wrdata = tx_dout;
          if (tx_cnt == 8'd1) tx_nx = TX_IDLE;
        end
      end
      default: tx_nx = TX_IDLE;
    endcase
    tx_fetch = live && tx_want && !c_rdempty[gnt] && (!tx_vld || tx_drain);
  end

  always_comb begin
    c_rden      = '0;
    c_rden[gnt] = tx_fetch;
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      live    <= 1'b0;
      tx_st   <= TX_IDLE;
      gnt     <= '0;
      rr_ptr  <= CHW'(NCH - 1);
      len_req <= 1'b0;
      tx_cnt  <= '0;
      tx_left <= '0;
    end else begin
      live  <= 1'b1;
      tx_st <= tx_nx;
      if (tx_st == TX_IDLE && any_req) begin
        gnt     <= gnt_nx;
        rr_ptr  <= gnt_nx;
        len_req <= 1'b0;
      end else if (tx_fetch) begin
        len_req <= 1'b1;
      end
      // tx_left counts payload bytes still to request; tx_cnt counts bytes still to write.
      if (tx_st == TX_LEN && tx_drain) begin
        tx_cnt  <= tx_dout;
        tx_left <= tx_dout - byte_t'(tx_fetch);
      end else if (tx_st == TX_DATA) begin
        if (tx_drain) tx_cnt <= tx_cnt - 8'd1;
        tx_left <= tx_left - byte_t'(tx_fetch);
      end
    end
  end

  host_link_hold #(.W(LEN_W)) u_tx_hold (
    .clk   (CLK),
    .rst_n (RESETn),
    .fetch (tx_fetch),
    .din   (tx_din),
    .drain (tx_drain),
    .valid (tx_vld),
    .dout  (tx_dout)
  );

  assign tx_busy = (tx_st != TX_IDLE);

  // ---------------- inbound ----------------
  rx_state_e      rx_st, rx_nx;
  logic [CHW-1:0] tgt;
  logic           bad;
  byte_t          rx_cnt;
  logic           rx_fetch, rx_drain, rx_vld, tgt_full;
  byte_t          rx_dout;

  always_comb begin
    rx_nx    = rx_st;
    rx_drain = 1'b0;
    c_wren   = '0;
    c_wrdata = '0;
    tgt_full = c_wrfull[tgt];
    case (rx_st)
      RX_CHAN: if (rx_vld) begin
        rx_drain = 1'b1;
        rx_nx    = RX_LEN;
      end
      RX_LEN: if (rx_vld && (bad || !tgt_full)) begin
        rx_drain = 1'b1;
        if (!bad) begin
          c_wren[tgt] = 1'b1;
          c_wrdata    = rx_dout;
        end
        rx_nx = (rx_dout == '0) ? RX_CHAN : RX_DATA;
      end
      RX_DATA: if (rx_vld && (bad || !tgt_full)) begin
        rx_drain = 1'b1;
        if (!bad) begin
          c_wren[tgt] = 1'b1;
          c_wrdata    = rx_dout;
        end
        if (rx_cnt == 8'd1) rx_nx = RX_CHAN;
      end
      default: rx_nx = RX_CHAN;
    endcase
  end

  assign rx_fetch = live && !com_rdempty && (!rx_vld || rx_drain);
  assign com_rden = rx_fetch;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      rx_st  <= RX_CHAN;
      tgt    <= '0;
      bad    <= 1'b0;
      rx_cnt <= '0;
    end else begin
      rx_st <= rx_nx;
      if (rx_st == RX_CHAN && rx_drain) begin
        tgt <= CHW'(rx_dout);
        bad <= (rx_dout >= byte_t'(NCH));
      end
      if (rx_st == RX_LEN && rx_drain) rx_cnt <= rx_dout;
      else if (rx_st == RX_DATA && rx_drain) rx_cnt <= rx_cnt - 8'd1;
    end
  end

`ifdef HOST_LINK_MUX_DROPCNT_EN
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) rx_dropped <= '0;
    else if (rx_st == RX_CHAN && rx_drain && rx_dout >= byte_t'(NCH) &&
             rx_dropped != 16'hFFFF)
      rx_dropped <= rx_dropped + 16'd1;
  end
`endif

  host_link_hold #(.W(LEN_W)) u_rx_hold (
    .clk   (CLK),
    .rst_n (RESETn),
    .fetch (rx_fetch),
    .din   (com_rddata),
    .drain (rx_drain),
    .valid (rx_vld),
    .dout  (rx_dout)
  );

  assign rx_busy = (rx_st != RX_CHAN);

endmodule

// File: tb/tb_host_link_mux.sv
// Randomized scoreboard bench for host_link_mux: FIFO models feed the DUT,
// a negedge monitor parses link/client writes against per-client expected byte queues.
`timescale 1ns/1ps
module tb_host_link_mux;

  localparam int NCH = 2;

  logic             CLK = 1'b0;
  logic             RESETn = 1'b0;
  logic             com_rden, com_wren;
  logic             com_rdempty = 1'b1;
  logic [7:0]       com_rddata = '0;
  logic             com_wrfull = 1'b0;
  logic [7:0]       com_wrdata;
  logic [NCH-1:0]   c_rden, c_wren;
  logic [NCH-1:0]   c_rdempty = '1;
  logic [8*NCH-1:0] c_rddata = '0;
  logic [NCH-1:0]   c_wrfull = '0;
  logic [7:0]       c_wrdata;
  logic             tx_busy, rx_busy;
`ifdef HOST_LINK_MUX_DROPCNT_EN
  logic [15:0]      rx_dropped;
`endif

  host_link_mux #(.NCH(NCH)) dut (
    .CLK(CLK), .RESETn(RESETn),
    .com_rden(com_rden), .com_rdempty(com_rdempty), .com_rddata(com_rddata),
    .com_wren(com_wren), .com_wrfull(com_wrfull), .com_wrdata(com_wrdata),
    .c_rden(c_rden), .c_rdempty(c_rdempty), .c_rddata(c_rddata),
    .c_wren(c_wren), .c_wrfull(c_wrfull), .c_wrdata(c_wrdata),
`ifdef HOST_LINK_MUX_DROPCNT_EN
    .rx_dropped(rx_dropped),
`endif
    .tx_busy(tx_busy), .rx_busy(rx_busy)
  );

  always #5 CLK = ~CLK;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // Source FIFOs, expected sink streams, and reference drop count.
  logic [7:0] src_tx[NCH][$];
  logic [7:0] exp_tx[NCH][$];
  logic [7:0] exp_rx[NCH][$];
  logic [7:0] src_rx[$];
  int         drop_model = 0;

  int fmode = 0;      // 0: never full, 1: random full, 2: c_wrfull[1] toggles
  int stall_req = 0;
  int cyc = 0;

  logic [NCH-1:0] rd_snap = '0;
  logic           crd_snap = 1'b0;

  always @(posedge CLK) cyc++;

  always @(negedge CLK) begin
    rd_snap  = c_rden;
    crd_snap = com_rden;
  end

  // FIFO models and backpressure drivers, updated just after each rising edge.
  always @(posedge CLK) begin
    #1;
    for (int i = 0; i < NCH; i++) begin
      if (rd_snap[i] && RESETn && src_tx[i].size() > 0) c_rddata[i*8 +: 8] = src_tx[i].pop_front();
      c_rdempty[i] = (src_tx[i].size() == 0);
    end
    if (crd_snap && RESETn && src_rx.size() > 0) com_rddata = src_rx.pop_front();
    com_rdempty = (src_rx.size() == 0);
    case (fmode)
      1: begin
        com_wrfull = ($urandom_range(0, 3) == 0);
        for (int i = 0; i < NCH; i++) c_wrfull[i] = ($urandom_range(0, 3) == 0);
      end
      2: begin
        com_wrfull  = 1'b0;
        c_wrfull[0] = 1'b0;
        c_wrfull[1] = ~c_wrfull[1];
      end
      default: begin
        com_wrfull = 1'b0;
        c_wrfull   = '0;
      end
    endcase
    if (stall_req > 0) begin
      com_wrfull = 1'b1;
      stall_req--;
    end
  end

  // Monitor: link stream parsed as channel / length / payload.
  int mst = 0, cur = 0, rem = 0, pay_cnt = 0;
  int cyc_log[$];
  int chan_log[$];
  int rx_cnt[NCH];

  initial for (int i = 0; i < NCH; i++) rx_cnt[i] = 0;

  always @(negedge CLK) begin
    if (!RESETn) begin
      mst = 0;
    end else begin
      if (com_wren) begin
        chk("com_wren_while_full", com_wrfull, 0);
        cyc_log.push_back(cyc);
        if (mst == 0) begin
          chk("tx_chan_range", (com_wrdata < NCH), 1);
          cur = (com_wrdata < NCH) ? int'(com_wrdata) : 0;
          chan_log.push_back(int'(com_wrdata));
          mst = 1;
        end else begin
          chk("tx_exp_nonempty", (exp_tx[cur].size() > 0), 1);
          if (exp_tx[cur].size() > 0) chk("tx_byte", com_wrdata, exp_tx[cur].pop_front());
          if (mst == 1) begin
            rem = int'(com_wrdata);
            mst = (rem == 0) ? 0 : 2;
          end else begin
            pay_cnt++;
            rem--;
            if (rem == 0) mst = 0;
          end
        end
      end
      if (c_wren != '0) begin
        chk("c_wren_onehot", $onehot(c_wren), 1);
        chk("c_wren_while_full", c_wren & c_wrfull, 0);
        for (int i = 0; i < NCH; i++) if (c_wren[i]) begin
          rx_cnt[i]++;
          chk("rx_exp_nonempty", (exp_rx[i].size() > 0), 1);
          if (exp_rx[i].size() > 0) chk("rx_byte", c_wrdata, exp_rx[i].pop_front());
        end
      end
    end
  end

  task automatic tx_pkt(input int ch, input int len);
    logic [7:0] b;
    src_tx[ch].push_back(8'(len));
    exp_tx[ch].push_back(8'(len));
    for (int k = 0; k < len; k++) begin
      b = 8'($urandom_range(0, 255));
      src_tx[ch].push_back(b);
      exp_tx[ch].push_back(b);
    end
  endtask

  task automatic rx_frame(input int ch, input int len);
    logic [7:0] b;
    src_rx.push_back(8'(ch));
    src_rx.push_back(8'(len));
    if (ch < NCH) exp_rx[ch].push_back(8'(len));
    else drop_model++;
    for (int k = 0; k < len; k++) begin
      b = 8'($urandom_range(0, 255));
      src_rx.push_back(b);
      if (ch < NCH) exp_rx[ch].push_back(b);
    end
  endtask

  function automatic bit all_drained();
    bit d;
    d = (src_rx.size() == 0) && com_rdempty && !tx_busy && !rx_busy;
    for (int i = 0; i < NCH; i++)
      d = d && (src_tx[i].size() == 0) && (exp_tx[i].size() == 0) &&
          (exp_rx[i].size() == 0) && c_rdempty[i];
    return d;
  endfunction

  task automatic wait_idle(input string nm, input int budget);
    int n;
    n = 0;
    repeat (3) begin @(negedge CLK); #1; end
    while (n < budget && !all_drained()) begin
      @(negedge CLK); #1;
      n++;
    end
    chk(nm, (n < budget), 1);
  endtask

  task automatic wait_pay(input string nm, input int target, input int budget);
    int n;
    n = 0;
    while (n < budget && pay_cnt < target) begin
      @(negedge CLK); #1;
      n++;
    end
    chk(nm, (n < budget), 1);
  endtask

  task automatic chk_outputs_zero(input string nm);
    chk({nm, "_com_rden"}, com_rden, 0);
    chk({nm, "_com_wren"}, com_wren, 0);
    chk({nm, "_com_wrdata"}, com_wrdata, 0);
    chk({nm, "_c_rden"}, c_rden, 0);
    chk({nm, "_c_wren"}, c_wren, 0);
    chk({nm, "_c_wrdata"}, c_wrdata, 0);
    chk({nm, "_tx_busy"}, tx_busy, 0);
    chk({nm, "_rx_busy"}, rx_busy, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int b0, b1, base;
    repeat (3) @(negedge CLK);
    #1;
    chk_outputs_zero("reset");
`ifdef HOST_LINK_MUX_DROPCNT_EN
    chk("reset_rx_dropped", rx_dropped, 0);
`endif
    RESETn = 1'b1;
    repeat (2) @(negedge CLK);
    #1;

    // Single packet from client 0, contiguous on the link.
    cyc_log.delete(); chan_log.delete();
    src_tx[0].push_back(8'h02); src_tx[0].push_back(8'hAA); src_tx[0].push_back(8'hBB);
    exp_tx[0].push_back(8'h02); exp_tx[0].push_back(8'hAA); exp_tx[0].push_back(8'hBB);
    wait_idle("t1_done", 200);
    chk("t1_write_count", cyc_log.size(), 4);
    if (cyc_log.size() == 4) chk("t1_contiguous", cyc_log[3] - cyc_log[0], 3);
    if (chan_log.size() > 0) chk("t1_channel", chan_log[0], 0);
    chk("t1_tx_busy_idle", tx_busy, 0);

    // Both clients backlogged: channel bytes must alternate.
    chan_log.delete();
    for (int k = 0; k < 3; k++) begin
      tx_pkt(0, $urandom_range(1, 4));
      tx_pkt(1, $urandom_range(1, 4));
    end
    wait_idle("t2_done", 500);
    chk("t2_packet_count", chan_log.size(), 6);
    for (int k = 1; k < chan_log.size(); k++)
      chk("t2_rr_alternate", (chan_log[k] != chan_log[k-1]), 1);

    // Five-cycle link stall in the middle of a long payload.
    base = pay_cnt;
    tx_pkt(0, 20);
    wait_pay("t3_reach_payload", base + 5, 200);
    stall_req = 5;
    repeat (5) begin
      @(negedge CLK); #1;
      chk("t3_no_c_rden_in_stall", c_rden, 0);
      chk("t3_no_com_wren_in_stall", com_wren, 0);
    end
    wait_idle("t3_done", 300);

    // Inbound frame to client 1, then again with client 1 toggling full.
    for (int pass = 0; pass < 2; pass++) begin
      fmode = (pass == 0) ? 0 : 2;
      b0 = rx_cnt[0]; b1 = rx_cnt[1];
      src_rx.push_back(8'h01); src_rx.push_back(8'h03); src_rx.push_back(8'h11);
      src_rx.push_back(8'h22); src_rx.push_back(8'h33);
      exp_rx[1].push_back(8'h03); exp_rx[1].push_back(8'h11);
      exp_rx[1].push_back(8'h22); exp_rx[1].push_back(8'h33);
      wait_idle("t4_done", 300);
      chk("t4_c1_writes", rx_cnt[1] - b1, 4);
      chk("t4_c0_writes", rx_cnt[0] - b0, 0);
    end
    fmode = 0;

    // Bad channel frame followed by an empty frame to client 0.
    b0 = rx_cnt[0]; b1 = rx_cnt[1];
    src_rx.push_back(8'h05); src_rx.push_back(8'h02); src_rx.push_back(8'hDE);
    src_rx.push_back(8'hAD); src_rx.push_back(8'h00); src_rx.push_back(8'h00);
    drop_model++;
    exp_rx[0].push_back(8'h00);
    wait_idle("t5_done", 300);
    chk("t5_c0_writes", rx_cnt[0] - b0, 1);
    chk("t5_c1_writes", rx_cnt[1] - b1, 0);
`ifdef HOST_LINK_MUX_DROPCNT_EN
    chk("t5_rx_dropped", rx_dropped, 32'(drop_model));
`endif

    // Randomized traffic both directions with random backpressure.
    fmode = 1;
    for (int k = 0; k < 40; k++) begin
      tx_pkt($urandom_range(0, NCH-1), $urandom_range(0, 10));
      rx_frame($urandom_range(0, NCH), $urandom_range(0, 10));
    end
    rx_frame(8'hFF, 3);
    wait_idle("t6_done", 20000);
    fmode = 0;
`ifdef HOST_LINK_MUX_DROPCNT_EN
    chk("t6_rx_dropped", rx_dropped, 32'(drop_model));
`endif
    repeat (2) @(negedge CLK);
    #1;

    // Reset in the middle of a payload, then restart from a clean state.
    base = pay_cnt;
    tx_pkt(0, 10);
    wait_pay("t7_reach_payload", base + 4, 200);
    RESETn = 1'b0;
    #1;
    chk_outputs_zero("t7_midreset");
`ifdef HOST_LINK_MUX_DROPCNT_EN
    chk("t7_rx_dropped", rx_dropped, 0);
`endif
    for (int i = 0; i < NCH; i++) begin
      src_tx[i].delete(); exp_tx[i].delete(); exp_rx[i].delete();
    end
    src_rx.delete();
    drop_model = 0;
    repeat (2) @(negedge CLK);
    #1;
    RESETn = 1'b1;
    @(negedge CLK); #1;
    chan_log.delete();
    tx_pkt(1, 1);
    tx_pkt(0, 1);
    wait_idle("t7_done", 300);
    chk("t7_packet_count", chan_log.size(), 2);
    if (chan_log.size() > 0) chk("t7_client0_first", chan_log[0], 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/host_link_mux.md
Name: host_link_mux

Overview:
- Multiplexes N byte-stream clients (host master, host slave, future agents) onto the single host transport FIFO pair.
- Framing decisions are made at packet boundaries.
- Outbound: prefixes each client packet with a channel byte.
- Inbound: strips the channel byte and steers length+payload to the addressed client. Sits between the clients and the dual-clock transport FIFOs.

Parameters:
- NCH, 2, number of clients (2..8); channel byte value = client index 0..NCH-1.
- (localparam) CHW, $clog2(NCH), grant/index width.

Ports:
- CLK  in  1  system clock
- RESETn  in  1  reset, asynchronous, active-low
- com_rden  out  1  read strobe to transport RX FIFO
- com_rdempty  in  1  transport RX FIFO empty
- com_rddata  in  8  transport RX data, valid the cycle after com_rden
- com_wren  out  1  write strobe to transport TX FIFO
- com_wrfull  in  1  transport TX FIFO full
- com_wrdata  out  8  transport TX data
- c_rden  out  NCH  per-client outbound read strobe
- c_rdempty  in  NCH  per-client outbound empty
- c_rddata  in  8*NCH  per-client outbound data, valid the cycle after c_rden
- c_wren  out  NCH  per-client inbound write strobe
- c_wrfull  in  NCH  per-client inbound full
- c_wrdata  out  8  inbound data, shared by all clients
- tx_busy  out  1  outbound packet in progress
- rx_busy  out  1  inbound packet in progress

Behaviour:
- Reset: all outputs 0, both FSMs idle, hold registers empty, round-robin pointer = NCH-1 (client 0 wins first). Async reset mid-packet drops all partial state and in-flight bytes.
- Packet format, both directions: length byte L (0..255), then L payload bytes. On the link, each packet is preceded by a channel byte.
- Read pipeline: FIFO data arrives one cycle after rden. Each direction has a one-entry hold register. rden is issued only when the source is not empty AND (hold is empty OR hold drains this cycle). Sustained rate is 1 byte/clk.
- TX FSM: TX_IDLE -> TX_CHAN -> TX_LEN -> TX_DATA -> TX_IDLE.
  - TX_IDLE: if any c_rdempty is low, grant the first non-empty client after the pointer (round robin), update the pointer, go to TX_CHAN. tx_busy=1 from the next cycle.
  - TX_CHAN: write channel byte {0, grant} when !com_wrfull, then go to TX_LEN. The client length read may be prefetched during this state.
  - TX_LEN: forward the length byte and load down-counter = L. If L==0, return to TX_IDLE after the write completes; otherwise go to TX_DATA.
  - TX_DATA: forward bytes, decrementing per completed com write. Go to TX_IDLE after the write of the last byte (counter 1->0).
  - Grant is locked for the whole packet. Other clients wait regardless of demand.
  - com_wrfull stalls the write; the hold register keeps its byte and no further c_rden is issued.
  - The pointer moves only at grant, so a lone requester is granted back-to-back with one idle cycle between packets.
- RX FSM: RX_CHAN -> RX_LEN -> RX_DATA -> RX_CHAN.
  - RX_CHAN: consume one byte as the target channel. If the value is >= NCH, mark the frame bad.
  - RX_LEN: write to target with c_wren[tgt] when !c_wrfull[tgt]; load counter = L. If L==0, go to RX_CHAN.
  - RX_DATA: forward L bytes, then go to RX_CHAN.
  - Bad frame: length and payload are consumed from com at full rate and never written to any client. c_wren stays 0.
  - Full target client stalls only RX; TX continues independently.
  - rx_busy=1 from acceptance of the channel byte until the last byte is written.
- TX and RX are fully independent and may run in the same cycle.
- c_wren and c_rden are one-hot or zero.

Optional Feature:
- HOST_LINK_MUX_DROPCNT_EN defined: adds output rx_dropped [15:0].
  - Saturating count of bad-channel frames, incremented when the bad channel byte is accepted.
  - Held at 0xFFFF once saturated; reset to 0.
- Undefined: port absent; bad frames are silently discarded.

Decomposition:
- Shared package host_link_pkg holds:
  - tx_state_e, rx_state_e enums
  - LEN_W=8 and the byte typedef
  - rr_next() function for round-robin selection
- Natural sub-module host_link_hold: one-entry hold/skid register with valid, load, drain. Instantiated twice, once per direction.

Test Plan:
- NCH=2, client0 queues {0x02,0xAA,0xBB} -> com TX sequence 0x00,0x02,0xAA,0xBB, contiguous at 1 byte/clk once primed; tx_busy then returns to 0.
- Both clients hold packets continuously -> com TX channel bytes alternate 0x00,0x01,0x00,...; no interleaving inside a packet.
- com_wrfull asserted 5 cycles mid-payload -> no byte lost or duplicated; c_rden held 0 while the hold register is full.
- RX stream 0x01,0x03,0x11,0x22,0x33 -> c_wren[1] pulses 4 times with 0x03,0x11,0x22,0x33; c_wren[0] stays 0. Repeat with c_wrfull[1] toggling every other cycle.
- RX stream 0x05,0x02,0xDE,0xAD,0x00,0x00 -> first frame discarded; client0 receives the single byte 0x00. With the macro defined, rx_dropped=1.
- Assert RESETn low mid-TX_DATA (L=10, 4 bytes sent) -> all outputs 0 immediately; after release, the next client packet starts with a channel byte.
